// File: rtl/axis_dest_router.sv
// axis_dest_router: 1-to-N AXI-Stream packet router (split side of the AXIS switch).
//
// The destination is taken from s_axis_tdest on the first beat of a packet and held
// until tlast. Beats pass through one registered output stage that sustains one beat
// per cycle. Packets whose destination is >= N are accepted and discarded.
//
// Optional build macro: ROUTER_STATS_EN adds a saturating 16-bit drop_count output.
//
// Ports:
//   clk            clock
//   res_n          synchronous active-low reset
//   enable         gates the start of new packets only
//   s_axis_*       input stream (tdata, tdest, tlast, tvalid, tready)
//   m_axis_tdata   output data, shared by all outputs
//   m_axis_tlast   output last flag, shared by all outputs
//   m_axis_tvalid  per-output valid, one-hot or zero
//   m_axis_tready  per-output ready
//   drop_count     dropped packet count (ROUTER_STATS_EN only)

module axis_dest_router #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 2
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [DEST_W-1:0] s_axis_tdest,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [N-1:0]      m_axis_tvalid,
    input  logic [N-1:0]      m_axis_tready
`ifdef ROUTER_STATS_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRoute, StDrop} state_e;

    state_e              state_q, state_d;
    logic                out_vld_q, out_vld_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;

    logic                drain;
    logic                can_load;
    logic                accept;
    logic                dest_ok;
    logic [SEL_W-1:0]    dest_sel;

    assign drain    = out_vld_q && m_axis_tready[out_sel_q];
    assign can_load = !out_vld_q || drain;
    assign accept   = s_axis_tvalid && s_axis_tready;
    assign dest_ok  = (32'(s_axis_tdest) < N);
    assign dest_sel = SEL_W'(s_axis_tdest);

    // Ready is held low throughout reset so upstream never sees a phantom handshake.
    always_comb begin
        s_axis_tready = 1'b0;
        if (res_n) begin
            case (state_q)
                StIdle:  s_axis_tready = enable && can_load;
                StRoute: s_axis_tready = can_load;
                StDrop:  s_axis_tready = 1'b1;
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_sel_d  = out_sel_q;
        cur_sel_d  = cur_sel_q;

        // A load in the same cycle overrides this, keeping out_vld set.
        if (drain) begin
            out_vld_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                StIdle: begin
                    if (dest_ok) begin
                        out_vld_d  = 1'b1;
                        out_data_d = s_axis_tdata;
                        out_last_d = s_axis_tlast;
                        out_sel_d  = dest_sel;
                        cur_sel_d  = dest_sel;
                        state_d    = s_axis_tlast ? StIdle : StRoute;
                    end else begin
                        state_d    = s_axis_tlast ? StIdle : StDrop;
                    end
                end
                StRoute: begin
                    // tdest on continuation beats is ignored.
                    out_vld_d  = 1'b1;
                    out_data_d = s_axis_tdata;
                    out_last_d = s_axis_tlast;
                    out_sel_d  = cur_sel_q;
                    if (s_axis_tlast) begin
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (s_axis_tlast) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q    <= StIdle;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_sel_q  <= '0;
            cur_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_sel_q  <= out_sel_d;
            cur_sel_q  <= cur_sel_d;
        end
    end

    assign m_axis_tdata = out_data_q;
    assign m_axis_tlast = out_last_q;

    always_comb begin
        m_axis_tvalid = '0;
        for (int unsigned i = 0; i < N; i++) begin
            m_axis_tvalid[i] = out_vld_q && (out_sel_q == SEL_W'(i));
        end
    end

`ifdef ROUTER_STATS_EN
    logic        drop_first;
    logic [15:0] drop_count_q, drop_count_d;

    assign drop_first = accept && (state_q == StIdle) && !dest_ok;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_first && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            drop_count_q <= 16'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: doc/axis_dest_router.md
Name: axis_dest_router

Overview:
- 1-to-N AXI-Stream packet router. It is the split side of the AXIS switch and the counterpart of the N-to-1 round-robin merge.
- A packet's destination is taken from tdest on its first beat and held until tlast.
- Beats pass through one registered output stage that supports full throughput.
- Packets with an out-of-range destination are consumed and discarded.

Parameters:
- N, 4, number of output ports (>=2).
- DATA_W, 32, tdata width in bits.
- DEST_W, 2, tdest width; values >= N are invalid.

Ports:
- clk  input  1  clock.
- res_n  input  1  synchronous active-low reset.
- enable  input  1  when low, no new packet is started; a packet already in progress completes.
- s_axis_tdata  input  DATA_W  input beat data.
- s_axis_tdest  input  DEST_W  destination; sampled on the first beat only.
- s_axis_tlast  input  1  last beat of packet.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when high together with tvalid.
- m_axis_tdata  output  DATA_W  output data, shared by all outputs.
- m_axis_tlast  output  1  output last flag, shared by all outputs.
- m_axis_tvalid  output  N  per-output valid; one-hot or zero.
- m_axis_tready  input  N  per-output ready.
- drop_count  output  16  number of dropped packets; present only with ROUTER_STATS_EN.

Behaviour:
- Clock and reset: single clock clk. Reset res_n is synchronous and active-low; it is sampled on the rising edge of clk.
- Reset state:
  - state=IDLE, out_vld=0, out_sel=0.
  - m_axis_tdata=0, m_axis_tlast=0, m_axis_tvalid=0.
  - s_axis_tready=0 during reset.
- Output register: one entry holding {data, last, sel} plus out_vld.
  - m_axis_tvalid[i] = out_vld && (out_sel==i).
  - drain = out_vld && m_axis_tready[out_sel].
  - can_load = !out_vld || drain.
- Input ready: s_axis_tready is a combinational function of state, out_vld, out_sel, m_axis_tready and enable.
  - IDLE: enable && can_load.
  - ROUTE: can_load.
  - DROP: 1.
- Latency and throughput: 1 cycle from input acceptance to m_axis_tvalid. Sustains 1 beat/cycle when the selected output holds tready high.
- IDLE, first beat accepted (s_axis_tvalid && s_axis_tready):
  - tdest<N: load the output register with sel=tdest and cur_sel=tdest. Go to ROUTE, or stay in IDLE if tlast=1 (single-beat packet).
  - tdest>=N: discard the beat and load nothing. Go to DROP, or stay in IDLE if tlast=1 (drop_count still increments).
- ROUTE:
  - Each accepted beat loads the output register with sel=cur_sel; tdest on these beats is ignored.
  - An accepted tlast returns the FSM to IDLE.
- DROP:
  - Beats are accepted every cycle and discarded.
  - An accepted tlast returns the FSM to IDLE.
- Output stability: while m_axis_tvalid[i] is high and m_axis_tready[i] is low, data, last and sel hold stable. Other outputs' tready has no effect.
- Back-to-back packets:
  - The first beat of the next packet may load in the same cycle the previous tlast drains, even to a different output.
  - out_sel changes only on load, so there are no idle cycles between packets.
- Simultaneous load and drain: the register is replaced and out_vld stays 1.
- enable low:
  - Mid-packet (ROUTE or DROP): ignored.
  - In IDLE: s_axis_tready=0 and no beat is consumed.
- Reset mid-packet:
  - The held beat is lost and the FSM returns to IDLE.
  - Remaining upstream beats are treated as a new packet, using their tdest.
  - Upstream must reset together with this block.

Optional Feature:
- Macro: ROUTER_STATS_EN.
- Defined:
  - 16-bit drop_count port and register; reset 0.
  - Increments by 1 on each accepted first beat with tdest>=N.
  - Saturates at 0xFFFF.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then a 3-beat packet (tdest=2, data 0xA0..0xA2) with m_axis_tready=4'b1111 -> m_axis_tvalid=4'b0100 for 3 consecutive cycles, first valid 1 cycle after acceptance, tlast on 0xA2.
- Packet to output 1 followed back-to-back by a packet to output 3 -> no bubble; m_axis_tvalid goes 0010 then 1000 on consecutive cycles.
- Out-of-range destination: N=3, DEST_W=2, 2-beat packet with tdest=3 -> s_axis_tready=1 both beats, m_axis_tvalid stays 0; with ROUTER_STATS_EN, drop_count 0->1.
- Backpressure: m_axis_tready[0]=0 for 5 cycles during a packet to output 0 -> s_axis_tready=0 after the first held beat, data stable, no beat lost or duplicated.
- tdest change mid-packet (beat 2 carries tdest=1 in a tdest=0 packet) -> all beats still on output 0.
- enable=0 in IDLE with s_axis_tvalid=1 -> s_axis_tready=0. enable=0 mid-packet -> packet completes. Reset asserted mid-packet -> all outputs 0 on the next cycle.
